multi_digit_seven_segment_display_controller: RTL and testbench
===============================================================

MULTI_DIGIT_SEVEN_SEGMENT_DISPLAY_CONTROLLER -- requirements
Module: multi_digit_seven_segment_display_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of unsigned binary input.
REQ-002 SHALL have parameter DIGIT_COUNT, default 3: number of multiplexed digits, minimum 1.
REQ-003 SHALL have parameter REFRESH_DIVISOR, default 100000: clk cycles each digit is held, minimum 2.
REQ-004 SHALL have parameter LEADING_ZERO_BLANK, default 1: 1 blanks leading zeros, 0 shows them.
REQ-005 SHALL have clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have load, input, 1: request to convert binary_value; honoured only while ready=1.
REQ-008 SHALL have binary_value, input, DATA_WIDTH: unsigned value sampled on an honoured load.
REQ-009 SHALL have dp_mask, input, DIGIT_COUNT: bit i=1 lights decimal point of digit i.
REQ-010 SHALL have ready, output, 1: converter idle, load accepted.
REQ-011 SHALL have done, output, 1: one-cycle pulse when a new value reaches the display.
REQ-012 SHALL have overflow, output, 1: displayed value exceeds 10^DIGIT_COUNT-1.
REQ-013 SHALL have digit_select, output, DIGIT_COUNT: one-hot active-low digit enable; bit 0 = rightmost (least significant).
REQ-014 SHALL have digit_change_tick, output, 1: one-cycle pulse when scan advances.
REQ-015 SHALL have display_bits, output, 8: active-low segments, [7]=dp, [6:0]=g,f,e,d,c,b,a.

Function
REQ-016 SHALL use internal BCD width 4*BCD_DIGITS, BCD_DIGITS=(DATA_WIDTH*302+999)/1000, and keep the larger of BCD_DIGITS and DIGIT_COUNT.
REQ-017 SHALL implement FSM IDLE -> CONVERT -> DONE -> IDLE; ready=1 only in IDLE.
REQ-018 SHALL on load=1 in IDLE capture binary_value, clear BCD register, enter CONVERT.
REQ-019 SHALL in CONVERT, each cycle, add 3 to every BCD nibble >=5, then shift {bcd,binary} left one bit; exactly DATA_WIDTH cycles.
REQ-020 SHALL in DONE (one cycle) copy BCD to display register, compute overflow, assert done, return to IDLE; done rises DATA_WIDTH+1 edges after the accepting edge.
REQ-021 SHALL ignore load outside IDLE; display register unchanged until DONE.
REQ-022 SHALL assert overflow when any BCD nibble at index >=DIGIT_COUNT is non-zero; while overflow=1 every digit shows dash (g only) with dp per dp_mask.
REQ-023 SHALL run a refresh counter 0..REFRESH_DIVISOR-1; at terminal count pulse digit_change_tick, wrap counter, advance scan index (DIGIT_COUNT-1 wraps to 0).
REQ-024 SHALL register digit_select and display_bits, reflecting current scan index, display register and dp_mask with one cycle latency.
REQ-025 SHALL, if LEADING_ZERO_BLANK=1 and no overflow, blank digit i (segments 1) when i>0 and all nibbles at index >=i are zero; digit 0 never blanked.
REQ-026 SHALL encode digits 0-9 standard active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp off).
REQ-027 SHALL keep scanning uninterrupted during conversion; done and digit_change_tick may coincide.

Reset
REQ-028 SHALL on reset low asynchronously force: IDLE, ready=1, done=0, overflow=0, display register 0, refresh counter 0, scan index 0, digit_change_tick=0.
REQ-029 SHALL drive during reset digit_select all ones except bit 0 low, display_bits=C0 (dp off).
REQ-030 SHALL abort conversion in progress on reset; nothing partial is displayed.

Verification (REFRESH_DIVISOR=4 for sim)
REQ-031 Reset: reset low -> digit_select=110, display_bits=C0, ready=1, done=0, overflow=0.
REQ-032 Load 123 (W=8,D=3): ready low next cycle, done one pulse 9 edges after load; scan digits 0,1,2 -> B0, A4, F9, each held 4 cycles, tick each change.
REQ-033 Load 7: digit 0=F8, digits 1,2=FF; with LEADING_ZERO_BLANK=0 digits 1,2=C0.
REQ-034 DIGIT_COUNT=2, load 100 -> overflow=1, both digits BF; then load 99 -> overflow=0, both 90.
REQ-035 Load 200 then load 50 mid-conversion -> 50 ignored, display 200; reset low mid-conversion -> display 0, no done pulse.
REQ-036 Display 123, dp_mask=010 -> digit 1 shows 24, others unchanged; change reflected one cycle later.

Source files
------------

// File: rtl/multi_digit_seven_segment_display_controller.sv
// Binary to BCD conversion (double-dabble) feeding a multiplexed, active-low
// seven-segment display with overflow dashes, leading-zero blanking and decimal points.
module multi_digit_seven_segment_display_controller #(
  parameter int DATA_WIDTH         = 8,
  parameter int DIGIT_COUNT        = 3,
  parameter int REFRESH_DIVISOR    = 100000,
  parameter int LEADING_ZERO_BLANK = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  binary_value,
  input  logic [DIGIT_COUNT-1:0] dp_mask,
  output logic                   ready,
  output logic                   done,
  output logic                   overflow,
  output logic [DIGIT_COUNT-1:0] digit_select,
  output logic                   digit_change_tick,
  output logic [7:0]             display_bits
);

  localparam int BCD_DIGITS = (DATA_WIDTH * 302 + 999) / 1000;
  localparam int NB         = (BCD_DIGITS > DIGIT_COUNT) ? BCD_DIGITS : DIGIT_COUNT;
  localparam int BW         = 4 * NB;
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
  localparam int REF_W      = $clog2(REFRESH_DIVISOR);
  localparam int SCAN_W     = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [DATA_WIDTH-1:0]  r_bin;
  logic [BW-1:0]          r_bcd, w_adj;
  logic [CNT_W-1:0]       r_cnt;
  logic [BW-1:0]          r_disp;
  logic                   r_ovf, w_ovf, r_done;
  logic [REF_W-1:0]       r_refresh;
  logic [SCAN_W-1:0]      r_scan;
  logic                   r_tick;
  logic [DIGIT_COUNT-1:0] r_sel, w_sel, w_upper_zero;
  logic [7:0]             r_seg;
  logic [3:0]             w_nib;
  logic                   w_dp, w_blank;
  logic [6:0]             w_seg7;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (load) w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Add-3 correction applied before each shift of the double-dabble step
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned k = 0; k < NB; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  always_comb begin
    w_ovf = 1'b0;
    for (int unsigned k = DIGIT_COUNT; k < NB; k++)
      if (r_bcd[4*k +: 4] != 4'd0) w_ovf = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_disp <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (load) begin
          r_bin <= binary_value;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_CONVERT: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          r_disp <= r_bcd;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit i is a leading zero when it and every more significant nibble are zero
  always_comb begin
    w_upper_zero = '1;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++)
      for (int unsigned k = i; k < NB; k++)
        if (r_disp[4*k +: 4] != 4'd0) w_upper_zero[i] = 1'b0;
  end

  always_comb begin
    w_nib   = r_disp[3:0];
    w_dp    = dp_mask[0];
    w_blank = 1'b0;
    for (int unsigned i = 0; i < DIGIT_COUNT; i++)
      if (r_scan == SCAN_W'(i)) begin
        w_nib   = r_disp[4*i +: 4];
        w_dp    = dp_mask[i];
        w_blank = (i != 0) && w_upper_zero[i];
      end
    w_sel = ~(DIGIT_COUNT'(1) << r_scan);
    if (r_ovf)                                     w_seg7 = 7'h3F;
    else if ((LEADING_ZERO_BLANK != 0) && w_blank) w_seg7 = 7'h7F;
    else                                           w_seg7 = seg7(w_nib);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_scan    <= '0;
      r_tick    <= 1'b0;
      r_sel     <= ~DIGIT_COUNT'(1);
      r_seg     <= 8'hC0;
    end else begin
      r_sel <= w_sel;
      r_seg <= {~w_dp, w_seg7};
      if (r_refresh == REF_W'(REFRESH_DIVISOR - 1)) begin
        r_refresh <= '0;
        r_tick    <= 1'b1;
        r_scan    <= (r_scan == SCAN_W'(DIGIT_COUNT - 1)) ? '0 : r_scan + SCAN_W'(1);
      end else begin
        r_refresh <= r_refresh + REF_W'(1);
        r_tick    <= 1'b0;
      end
    end
  end

  assign ready             = (r_state == S_IDLE);
  assign done              = r_done;
  assign overflow          = r_ovf;
  assign digit_select      = r_sel;
  assign digit_change_tick = r_tick;
  assign display_bits      = r_seg;

endmodule

// File: tb/tb_multi_digit_seven_segment_display_controller.sv
// Self-checking bench: three parameterisations (blanking on, blanking off, two digits)
// driven in lockstep and compared against a decimal-arithmetic reference model.
module tb_multi_digit_seven_segment_display_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] value = '0;
  logic [2:0] dp = '0;

  logic       rdy0, rdy1, rdy2, dn0, dn1, dn2, ovf0, ovf1, ovf2, tk0, tk1, tk2;
  logic [2:0] sel0, sel1;
  logic [1:0] sel2;
  logic [7:0] bits0, bits1, bits2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_digit_seven_segment_display_controller #(
    .DATA_WIDTH(8), .DIGIT_COUNT(3), .REFRESH_DIVISOR(4), .LEADING_ZERO_BLANK(1)
  ) u0 (
    .clk(clk), .reset(reset), .load(load), .binary_value(value), .dp_mask(dp),
    .ready(rdy0), .done(dn0), .overflow(ovf0), .digit_select(sel0),
    .digit_change_tick(tk0), .display_bits(bits0)
  );

  multi_digit_seven_segment_display_controller #(
    .DATA_WIDTH(8), .DIGIT_COUNT(3), .REFRESH_DIVISOR(4), .LEADING_ZERO_BLANK(0)
  ) u1 (
    .clk(clk), .reset(reset), .load(load), .binary_value(value), .dp_mask(dp),
    .ready(rdy1), .done(dn1), .overflow(ovf1), .digit_select(sel1),
    .digit_change_tick(tk1), .display_bits(bits1)
  );

  multi_digit_seven_segment_display_controller #(
    .DATA_WIDTH(8), .DIGIT_COUNT(2), .REFRESH_DIVISOR(4), .LEADING_ZERO_BLANK(1)
  ) u2 (
    .clk(clk), .reset(reset), .load(load), .binary_value(value), .dp_mask(dp[1:0]),
    .ready(rdy2), .done(dn2), .overflow(ovf2), .digit_select(sel2),
    .digit_change_tick(tk2), .display_bits(bits2)
  );

  typedef struct {
    int         val;
    logic [2:0] dpm;
    logic [7:0] e0, e1, e2;   // 3-digit, blanking on
    logic [7:0] g0, g1;       // 2-digit
    logic       govf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] get_sel(input int inst);
    if (inst == 0) return sel0;
    if (inst == 1) return sel1;
    return {1'b1, sel2};
  endfunction

  function automatic logic [7:0] get_bits(input int inst);
    if (inst == 0) return bits0;
    if (inst == 1) return bits1;
    return bits2;
  endfunction

  function automatic logic get_ovf(input int inst);
    if (inst == 0) return ovf0;
    if (inst == 1) return ovf1;
    return ovf2;
  endfunction

  function automatic int ndig(input int inst);
    return (inst == 2) ? 2 : 3;
  endfunction

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int k = 0; k < e; k++) p *= 10;
    return p;
  endfunction

  // Reference: decimal digits by division, dash beyond range, blank above the top digit
  function automatic logic [7:0] model_bits(input int val, input int i, input logic dpb,
                                            input int nd, input bit lzb);
    logic [6:0] pat [10];
    logic [6:0] s;
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (val >= pow10(nd))                 s = 7'h3F;
    else if (lzb && i > 0 && val < pow10(i)) s = 7'h7F;
    else                                  s = pat[(val / pow10(i)) % 10];
    return {~dpb, s};
  endfunction

  task automatic check_digit(input int inst, input int i, input logic [7:0] exp,
                             input string name);
    logic [2:0] es;
    int t;
    es = ~(3'b001 << i);
    t = 0;
    while (get_sel(inst) !== es && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({name, " select"}, get_sel(inst), es);
    chk({name, " segments"}, get_bits(inst), exp);
  endtask

  task automatic check_all(input int v, input logic [2:0] d);
    for (int inst = 0; inst < 3; inst++) begin
      for (int i = 0; i < ndig(inst); i++)
        check_digit(inst, i, model_bits(v, i, d[i], ndig(inst), inst != 1),
                    $sformatf("u%0d v=%0d digit%0d", inst, v, i));
      chk($sformatf("u%0d v=%0d overflow", inst, v), get_ovf(inst), v >= pow10(ndig(inst)));
    end
  endtask

  task automatic do_load(input int v, input logic [2:0] d);
    int t, first0, first2, highs0, highs2;
    t = 0;
    while (!rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    value = 8'(v);
    dp    = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    chk("ready low after accept", rdy0, 1'b0);
    first0 = 0; first2 = 0; highs0 = 0; highs2 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dn0) begin highs0++; if (first0 == 0) first0 = k; end
      if (dn2) begin highs2++; if (first2 == 0) first2 = k; end
    end
    chk($sformatf("done latency v=%0d", v), first0, 9);
    chk($sformatf("done width v=%0d", v), highs0, 1);
    chk($sformatf("u2 done latency v=%0d", v), first2, 9);
  endtask

  initial begin
    vec_t tbl [7];
    logic [2:0] prev;
    int t, gap, cnt;

    tbl[0] = '{val:123, dpm:3'b000, e0:8'hB0, e1:8'hA4, e2:8'hF9, g0:8'hBF, g1:8'hBF, govf:1'b1};
    tbl[1] = '{val:7,   dpm:3'b000, e0:8'hF8, e1:8'hFF, e2:8'hFF, g0:8'hF8, g1:8'hFF, govf:1'b0};
    tbl[2] = '{val:0,   dpm:3'b000, e0:8'hC0, e1:8'hFF, e2:8'hFF, g0:8'hC0, g1:8'hFF, govf:1'b0};
    tbl[3] = '{val:255, dpm:3'b000, e0:8'h92, e1:8'h92, e2:8'hA4, g0:8'hBF, g1:8'hBF, govf:1'b1};
    tbl[4] = '{val:40,  dpm:3'b101, e0:8'h40, e1:8'h99, e2:8'h7F, g0:8'h40, g1:8'h99, govf:1'b0};
    tbl[5] = '{val:100, dpm:3'b000, e0:8'hC0, e1:8'hC0, e2:8'hF9, g0:8'hBF, g1:8'hBF, govf:1'b1};
    tbl[6] = '{val:99,  dpm:3'b110, e0:8'h90, e1:8'h10, e2:8'h7F, g0:8'h90, g1:8'h10, govf:1'b0};

    // Reset state
    @(negedge clk);
    chk("reset select", sel0, 3'b110);
    chk("reset segments", bits0, 8'hC0);
    chk("reset ready", rdy0, 1'b1);
    chk("reset done", dn0, 1'b0);
    chk("reset overflow", ovf0, 1'b0);
    chk("reset tick", tk0, 1'b0);
    reset = 1'b1;

    // Scan cadence: each digit held REFRESH_DIVISOR cycles, select follows the tick
    for (int n = 0; n < 3; n++) begin
      t = 0;
      while (!tk0 && t < 20) begin @(negedge clk); t++; end
      prev = sel0;
      @(negedge clk);
      chk("scan advance", sel0, {prev[1:0], prev[2]});
      gap = 1;
      while (!tk0 && gap < 20) begin @(negedge clk); gap++; end
      chk("tick spacing", gap, 4);
    end

    // Directed table
    foreach (tbl[n]) begin
      do_load(tbl[n].val, tbl[n].dpm);
      check_digit(0, 0, tbl[n].e0, $sformatf("tbl v=%0d d0", tbl[n].val));
      check_digit(0, 1, tbl[n].e1, $sformatf("tbl v=%0d d1", tbl[n].val));
      check_digit(0, 2, tbl[n].e2, $sformatf("tbl v=%0d d2", tbl[n].val));
      check_digit(2, 0, tbl[n].g0, $sformatf("tbl2 v=%0d d0", tbl[n].val));
      check_digit(2, 1, tbl[n].g1, $sformatf("tbl2 v=%0d d1", tbl[n].val));
      chk($sformatf("tbl2 v=%0d overflow", tbl[n].val), ovf2, tbl[n].govf);
      check_all(tbl[n].val, tbl[n].dpm);
    end

    // Load during conversion is ignored
    value = 8'd200; dp = 3'b000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    value = 8'd50; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    t = 0;
    while (!dn0 && t < 20) begin @(negedge clk); t++; end
    chk("done seen after ignored load", dn0, 1'b1);
    repeat (3) @(negedge clk);
    check_all(200, 3'b000);

    // Reset mid-conversion aborts: no done, display cleared
    value = 8'd77; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort ready", rdy0, 1'b1);
    chk("abort select", sel0, 3'b110);
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (dn0) cnt++;
    end
    chk("no done after abort", cnt, 0);
    check_all(0, 3'b000);

    // Decimal point update visible one cycle later
    do_load(123, 3'b000);
    t = 0;
    while (sel0 === 3'b101 && t < 20) begin @(negedge clk); t++; end
    while (sel0 !== 3'b101 && t < 40) begin @(negedge clk); t++; end
    chk("dp before change", bits0, 8'hA4);
    dp = 3'b010;
    @(negedge clk);
    chk("dp select held", sel0, 3'b101);
    chk("dp after change", bits0, 8'h24);
    check_all(123, 3'b010);

    // Randomised loads against the model
    for (int n = 0; n < 25; n++) begin
      int v;
      logic [2:0] d;
      v = int'($urandom_range(0, 255));
      d = 3'($urandom_range(0, 7));
      do_load(v, d);
      check_all(v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
